genesis_pad_responder: RTL and testbench
========================================

Name: genesis_pad_responder

Overview:
- Emulates a 6-button Genesis-style gamepad: the device end of the pad link whose host end is the `controller` reader.
- Watches the host's select line and drives the six active-low pad lines (up_z, down_y, left_x, right, a_b, start_c) per select phase.
- Used as a loopback/bench stand-in for a physical pad, and to feed the robot from on-board switches.

Parameters:
- TIMEOUT_CYCLES, 75000, clk cycles without a select edge before the phase counter returns to 0 (1.5 ms at 50 MHz).
- TO_W, 17, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock (50 MHz).
- reset  input  1  asynchronous, active-high reset.
- buttons  input  12  pressed=1: [0]up [1]down [2]left [3]right [4]a [5]b [6]c [7]x [8]y [9]z [10]start [11]mode.
- select_signal  input  1  host select line; asynchronous, 2-flop synchronized internally.
- up_z, down_y, left_x, right, a_b, start_c  output  1 each  pad lines, active-low (0 = pressed or forced low).
- phase  output  3  current select phase, debug.
- scan_active  output  1  high while phase != 0.

Behaviour:
- Reset values:
  - sync flops = 1; phase = 0; timeout counter = 0; snapshot = 0.
  - All six pad outputs = 1; scan_active = 0.
- Edge detection:
  - Any change of the synchronized select (rise or fall) is an edge.
  - On an edge, phase = phase+1 mod 8 (7 wraps to 0) and the timeout counter clears.
- Timeout:
  - With no edge, the counter increments and saturates.
  - When it reaches TIMEOUT_CYCLES-1, phase is forced to 0 on the next clk.
  - An edge in that same cycle takes priority: phase increments and the counter clears.
- Snapshot:
  - The buttons register loads every clk while phase==0 and no edge is detected that cycle.
  - It is frozen while phase != 0, so one scan frame sees a consistent button set.
- Output table (pressed button drives 0; "0" = driven low, "1" = released high). The synchronized select level picks the table:
  - sel=1, phase != 6: up, down, left, right, b, c onto up_z, down_y, left_x, right, a_b, start_c.
  - sel=1, phase == 6: z, y, x, mode, b, c.
  - sel=0, phase 1 or 3: up, down, 0, 0, a, start.
  - sel=0, phase 5: 0, 0, 0, 0, a, start (6-button ID).
  - sel=0, phase 7: 1, 1, 1, 1, a, start.
  - sel=0, phase even (host started low or sync lost): same as phase 1.
- Latency: outputs are registered. The new value appears 1 clk after the synchronized edge, i.e. 3 clk after a raw select change.
- Buttons changing mid-frame have no effect until phase returns to 0.
- Reset mid-frame: immediate return to reset values; the next frame starts at phase 0.
- phase and scan_active are combinational from the phase register.

Optional Feature:
- Macro: SIX_BUTTON_EN.
- Defined: full 8-phase behaviour as above.
- Undefined: 3-button pad.
  - sel=1 always drives up, down, left, right, b, c.
  - sel=0 always drives up, down, 0, 0, a, start.
  - x, y, z and mode are ignored; the phase counter and timeout still run, for debug only.

Test Plan:
- Reset, then release with select=1, buttons=0 -> all six outputs 1, phase=0, scan_active=0.
- buttons up+b (0x021), select=1 held -> up_z=0, a_b=0, others 1.
- Drop select to 0 -> 3 clk later: up_z=0, left_x=0, right=0, down_y=1; phase=1.
- Six-button frame with buttons z+mode+a (0xA10):
  - Toggle select 7 times at 1 µs spacing.
  - Phase 5 (low): first four outputs 0, a_b=0.
  - Phase 6 (high): up_z=0, right=0, others 1.
  - Phase 7 (low): first four outputs 1, a_b=0.
- Stop toggling at phase 3 -> after exactly TIMEOUT_CYCLES clk, phase=0 and scan_active=0. Set TIMEOUT_CYCLES=100 for this test.
- Change buttons from 0x001 to 0x002 while phase=2 -> outputs keep showing up until phase returns to 0. Build once without SIX_BUTTON_EN: in phase 6 the outputs show the D-pad, not z/y/x/mode.

Source files
------------

// File: rtl/genesis_pad_responder.sv
// genesis_pad_responder
//   Device end of a Genesis-style gamepad link. Follows the host's select
//   line through its select phases and drives the six active-low pad lines
//   from a per-frame snapshot of the button inputs.
//
//   Build option: define SIX_BUTTON_EN for the full 6-button, 8-phase pad.
//   Left undefined, the block behaves as a 3-button pad. The phase counter
//   and timeout still run in that build, but only for debug visibility.
//
// Parameters
//   TIMEOUT_CYCLES  clk cycles without a select edge before phase returns to 0
//   TO_W            width of the timeout counter; must hold TIMEOUT_CYCLES
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high reset
//   buttons[11:0]  pressed=1: up,down,left,right,a,b,c,x,y,z,start,mode (bit 0..11)
//   select_signal  host select line, asynchronous to clk
//   up_z .. start_c  active-low pad lines
//   phase[2:0]     current select phase (debug)
//   scan_active    high while a scan frame is in progress (phase != 0)

module genesis_pad_responder #(
    parameter int TIMEOUT_CYCLES = 75000,
    parameter int TO_W           = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] buttons,
    input  logic        select_signal,
    output logic        up_z,
    output logic        down_y,
    output logic        left_x,
    output logic        right,
    output logic        a_b,
    output logic        start_c,
    output logic [2:0]  phase,
    output logic        scan_active
);

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_X     = 7;
    localparam int BTN_Y     = 8;
    localparam int BTN_Z     = 9;
    localparam int BTN_START = 10;
    localparam int BTN_MODE  = 11;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic            sel_meta;
    logic            sel_sync;
    logic            sel_prev;
    logic [2:0]      phase_q;
    logic [TO_W-1:0] to_cnt;
    logic [11:0]     snapshot;
    // Pad lines packed MSB-first: {up_z, down_y, left_x, right, a_b, start_c}
    logic [5:0]      pad_q;

    logic            sel_edge;
    logic            timed_out;
    logic [2:0]      phase_next;
    logic [11:0]     snap_next;

    // Pad line pattern for a given select level, phase and button set.
    // Pressed buttons pull their line low.
    function automatic logic [5:0] pad_lines(input logic       sel,
                                             input logic [2:0] ph,
                                             input logic [11:0] b);
        logic [5:0] lines;
`ifdef SIX_BUTTON_EN
        if (sel) begin
            if (ph == 3'd6)
                lines = ~{b[BTN_Z], b[BTN_Y], b[BTN_X], b[BTN_MODE], b[BTN_B], b[BTN_C]};
            else
                lines = ~{b[BTN_UP], b[BTN_DOWN], b[BTN_LEFT], b[BTN_RIGHT], b[BTN_B], b[BTN_C]};
        end else begin
            case (ph)
                // Left/right both low is the 6-button identification pattern
                3'd5:    lines = {4'b0000, ~b[BTN_A], ~b[BTN_START]};
                3'd7:    lines = {4'b1111, ~b[BTN_A], ~b[BTN_START]};
                // Phases 1 and 3, plus even phases seen when sync was lost
                default: lines = {~b[BTN_UP], ~b[BTN_DOWN], 2'b00, ~b[BTN_A], ~b[BTN_START]};
            endcase
        end
`else
        if (sel)
            lines = ~{b[BTN_UP], b[BTN_DOWN], b[BTN_LEFT], b[BTN_RIGHT], b[BTN_B], b[BTN_C]};
        else
            lines = {~b[BTN_UP], ~b[BTN_DOWN], 2'b00, ~b[BTN_A], ~b[BTN_START]};
`endif
        return lines;
    endfunction

`ifndef SIX_BUTTON_EN
    // Phase and the x/y/z/mode buttons do not reach the pad lines on a 3-button pad
    logic unused_six_button;
    assign unused_six_button = ^{phase_next, snap_next[BTN_MODE], snap_next[BTN_Z],
                                 snap_next[BTN_Y], snap_next[BTN_X]};
`endif

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        sel_edge  = sel_sync ^ sel_prev;
        timed_out = (to_cnt == TO_LAST);

        // A select edge wins over a timeout landing in the same cycle
        if (sel_edge)
            phase_next = phase_q + 3'd1;
        else if (timed_out)
            phase_next = 3'd0;
        else
            phase_next = phase_q;

        // Track the buttons only while idle, so a frame sees one consistent set
        if (phase_q == 3'd0 && !sel_edge)
            snap_next = buttons;
        else
            snap_next = snapshot;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_meta <= 1'b1;
            sel_sync <= 1'b1;
            sel_prev <= 1'b1;
            phase_q  <= 3'd0;
            to_cnt   <= '0;
            snapshot <= '0;
            pad_q    <= 6'b111111;
        end else begin
            sel_meta <= select_signal;
            sel_sync <= sel_meta;
            sel_prev <= sel_sync;
            phase_q  <= phase_next;
            snapshot <= snap_next;

            if (sel_edge)
                to_cnt <= '0;
            else if (!timed_out)
                to_cnt <= to_cnt + TO_W'(1);

            // Registered from next-state values: the pad updates on the same
            // edge as the phase it belongs to
            pad_q <= pad_lines(sel_sync, phase_next, snap_next);
        end
    end

    assign up_z    = pad_q[5];
    assign down_y  = pad_q[4];
    assign left_x  = pad_q[3];
    assign right   = pad_q[2];
    assign a_b     = pad_q[1];
    assign start_c = pad_q[0];

    assign phase       = phase_q;
    assign scan_active = (phase_q != 3'd0);

endmodule

// File: tb/tb_genesis_pad_responder.sv
// Bench for genesis_pad_responder. Pad values are compared as a 6-bit
// vector {up_z, down_y, left_x, right, a_b, start_c}. Expectations follow
// the SIX_BUTTON_EN setting of the build.

module tb_genesis_pad_responder;

    localparam int TO  = 100;
    localparam int GAP = 50;   // 1 us at 50 MHz

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] buttons;
    logic        select_signal;
    logic        up_z, down_y, left_x, right, a_b, start_c;
    logic [2:0]  phase;
    logic        scan_active;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic        sel;
        logic [5:0]  pad;
        logic [2:0]  ph;
    } vec_t;

    vec_t frame[8];

    genesis_pad_responder #(.TIMEOUT_CYCLES(TO), .TO_W(17)) dut (
        .clk           (clk),
        .reset         (reset),
        .buttons       (buttons),
        .select_signal (select_signal),
        .up_z          (up_z),
        .down_y        (down_y),
        .left_x        (left_x),
        .right         (right),
        .a_b           (a_b),
        .start_c       (start_c),
        .phase         (phase),
        .scan_active   (scan_active)
    );

    always #10 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [5:0] exp_pad,
                               input logic [2:0] exp_ph);
        check({name, " pad"}, int'({up_z, down_y, left_x, right, a_b, start_c}), int'(exp_pad));
        check({name, " phase"}, int'(phase), int'(exp_ph));
        check({name, " scan"}, int'(scan_active), int'(exp_ph != 3'd0));
    endtask

    initial begin
        // Frame with z+mode+a pressed, starting idle with select high
        frame[0] = '{"f_ph1", 1'b0, 6'b110001, 3'd1};
        frame[1] = '{"f_ph2", 1'b1, 6'b111111, 3'd2};
        frame[2] = '{"f_ph3", 1'b0, 6'b110001, 3'd3};
        frame[3] = '{"f_ph4", 1'b1, 6'b111111, 3'd4};
`ifdef SIX_BUTTON_EN
        frame[4] = '{"f_ph5", 1'b0, 6'b000001, 3'd5};
        frame[5] = '{"f_ph6", 1'b1, 6'b011011, 3'd6};
        frame[6] = '{"f_ph7", 1'b0, 6'b111101, 3'd7};
`else
        frame[4] = '{"f_ph5", 1'b0, 6'b110001, 3'd5};
        frame[5] = '{"f_ph6", 1'b1, 6'b111111, 3'd6};
        frame[6] = '{"f_ph7", 1'b0, 6'b110001, 3'd7};
`endif
        frame[7] = '{"f_wrap", 1'b1, 6'b111111, 3'd0};

        // Reset
        reset = 1'b1;
        select_signal = 1'b1;
        buttons = 12'h000;
        tick(3);
        check_state("in_reset", 6'b111111, 3'd0);
        reset = 1'b0;
        tick(5);
        check_state("after_reset", 6'b111111, 3'd0);

        // Idle with up+b pressed
        buttons = 12'h021;
        tick(3);
        check_state("idle_up_b", 6'b011101, 3'd0);

        // Select falls: nothing for two clocks, new value on the third
        select_signal = 1'b0;
        tick(2);
        check_state("sel_low_lat2", 6'b011101, 3'd0);
        tick(1);
        check_state("sel_low_lat3", 6'b010011, 3'd1);

        // Back high, then let the timeout end the frame
        select_signal = 1'b1;
        tick(GAP);
        check_state("sel_high_ph2", 6'b011101, 3'd2);
        tick(TO + 10);
        check_state("to_idle", 6'b011101, 3'd0);

        // Full frame from the table
        buttons = 12'hA10;
        tick(5);
        for (int i = 0; i < 8; i++) begin
            select_signal = frame[i].sel;
            tick(GAP);
            check_state(frame[i].name, frame[i].pad, frame[i].ph);
        end

        // Edge landing on the last timeout cycle wins
        select_signal = 1'b0;
        tick(3);
        check("prio_ph1", int'(phase), 1);
        tick(TO - 3);
        select_signal = 1'b1;
        tick(3);
        check("prio_edge_wins", int'(phase), 2);

        // Stall at phase 3: phase returns to 0 exactly TO clocks later
        select_signal = 1'b0;
        tick(3);
        check("stall_ph3", int'(phase), 3);
        tick(TO - 1);
        check_state("to_minus1", 6'b110001, 3'd3);
        tick(1);
        check_state("to_exact", 6'b110001, 3'd0);

        // Buttons change mid-frame: snapshot holds until phase 0
        buttons = 12'h001;
        tick(5);
        select_signal = 1'b1;
        tick(GAP);
        check_state("mf_ph1", 6'b011111, 3'd1);
        select_signal = 1'b0;
        tick(GAP);
        buttons = 12'h002;
        tick(5);
        check_state("mf_ph2", 6'b010011, 3'd2);
        select_signal = 1'b1;
        tick(GAP);
        check_state("mf_ph3", 6'b011111, 3'd3);
        tick(TO + 10);
        check_state("mf_reload", 6'b101111, 3'd0);

        // Reset mid-frame
        select_signal = 1'b0;
        tick(GAP);
        check("rst_mid_ph1", int'(phase), 1);
        reset = 1'b1;
        #1;
        check_state("rst_async", 6'b111111, 3'd0);
        select_signal = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(5);
        check_state("rst_release", 6'b101111, 3'd0);
        select_signal = 1'b0;
        tick(3);
        check_state("rst_next_ph1", 6'b100011, 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
